pixel_write_sink: RTL and testbench

//  Receiving end of the plot interface driven by the note-drawing controllers (plot strobe + x/y/colour).
//  - Clips each plot request, converts x/y to a linear framebuffer address and buffers the write in a small FIFO.
//  - Issues each buffered write to the framebuffer write port with a valid/ready handshake.
//  - Also performs a full-screen clear sweep on request.
//  - Sits between the drop_notes control/datapath and the framebuffer RAM / VGA adapter.

---
 rtl/gh_video_pkg.sv | 31 +++
 rtl/pixel_write_sink_if.sv | 25 ++
 rtl/pixel_fifo.sv | 55 +++++
 rtl/pixel_write_sink.sv | 152 +++++++++++++++
 tb/tb_pixel_write_sink.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gh_video_pkg.sv
// Shared video constants, write-bundle type and sink FSM encodings.
// Imported by the plot sink, its FIFO and the framebuffer write interface.
package gh_video_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int ADDR_W   = 15;
  localparam int NPIX     = SCREEN_W * SCREEN_H;

  localparam logic [COLOUR_W-1:0] CLEAR_COLOUR = '0;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [COLOUR_W-1:0] colour;
  } px_wr_t;

  function automatic logic [ADDR_W-1:0] xy_to_addr(
    input logic [X_W-1:0] x,
    input logic [Y_W-1:0] y
  );
    return ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_write_sink_if.sv
// Framebuffer write port: valid/ready handshake carrying address and colour.
// The sink drives the master side, the framebuffer RAM the slave side.
interface pixel_write_sink_if;
  import gh_video_pkg::*;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [COLOUR_W-1:0] wr_data;
  logic                wr_ready;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/pixel_fifo.sv
// Show-ahead synchronous FIFO of buffered pixel writes.
// Head is valid whenever the FIFO is not empty.
module pixel_fifo
  import gh_video_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  px_wr_t                 i_data,
  input  logic                   i_pop,
  output px_wr_t                 o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PW = $clog2(DEPTH);

  px_wr_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW:0]   r_cnt;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rd];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt
             + {{PW{1'b0}}, w_push}
             - {{PW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/pixel_write_sink.sv
// Plot sink: clips plots, buffers linear-address writes and issues them
// to the framebuffer, with a full-screen clear sweep on request.
module pixel_write_sink
  import gh_video_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_plot,
  input  logic [X_W-1:0]      i_x,
  input  logic [Y_W-1:0]      i_y,
  input  logic [COLOUR_W-1:0] i_colour,
  input  logic                i_clear,
  output logic                o_busy,
  output logic                o_clip,
  output logic                o_overflow,
  output logic                o_clear_done,
  pixel_write_sink_if.master  fb
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

  logic [1:0]        r_state;
  logic              r_pend;
  logic [ADDR_W-1:0] r_sweep;
  logic              r_stg_v;
  px_wr_t            r_stg;
  logic              r_clip;
  logic              r_ovf;
  logic              r_done;

  px_wr_t          w_head;
  logic [CW-1:0]   w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_inb;
  logic            w_acc;
  logic            w_push;
  logic            w_pop;
  logic            w_hs;
  logic            w_idle;
  logic            w_wr;
  logic            w_clr;

  assign w_idle = (r_state == IDLE);
  assign w_wr   = (r_state == WRITE);
  assign w_clr  = (r_state == CLEAR);

  assign w_inb = (i_x < X_W'(SCREEN_W))
              && (i_y < Y_W'(SCREEN_H));

  // i_clear counts as busy in its own cycle so a coincident plot is dropped
  assign o_busy = (w_count + CW'(r_stg_v) >= CW'(FIFO_DEPTH))
               || w_clr || r_pend || i_clear;

  assign w_acc  = i_plot && !o_busy;
  assign w_push = r_stg_v && !w_full;
  assign w_hs   = fb.wr_en && fb.wr_ready;
  assign w_pop  = w_hs && w_wr;

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (r_stg),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stg_v <= 1'b0;
      r_stg   <= '0;
      r_clip  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_stg_v <= w_acc && w_inb;
      if (w_acc && w_inb) begin
        r_stg.addr   <= xy_to_addr(i_x, i_y);
        r_stg.colour <= i_colour;
      end
      r_clip <= w_acc && !w_inb;
      if (i_clear)
        r_ovf <= 1'b0;
      else if (i_plot && o_busy)
        r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pend  <= 1'b0;
      r_sweep <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (1'b1)
        w_idle: begin
          if (i_clear || r_pend) begin
            r_state <= CLEAR;
            r_pend  <= 1'b0;
          end else if (!w_empty || w_push) begin
            r_state <= WRITE;
          end
        end
        w_wr: begin
          if (w_hs) begin
            if (r_pend || i_clear) begin
              r_state <= CLEAR;
              r_pend  <= 1'b0;
            end else if (w_count == CW'(1) && !w_push) begin
              r_state <= IDLE;
            end
          end else if (i_clear) begin
            r_pend <= 1'b1;
          end
        end
        w_clr: begin
          if (w_hs) begin
            if (r_sweep == LAST) begin
              r_sweep <= '0;
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_sweep <= r_sweep + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fb.wr_en   = w_wr || w_clr;
  assign fb.wr_addr = w_clr ? r_sweep
                    : w_wr  ? w_head.addr
                    : '0;
  assign fb.wr_data = w_clr ? CLEAR_COLOUR
                    : w_wr  ? w_head.colour
                    : '0;

  assign o_clip       = r_clip;
  assign o_overflow   = r_ovf;
  assign o_clear_done = r_done;

endmodule

// File: tb/tb_pixel_write_sink.sv
// Scoreboard bench for pixel_write_sink: expected writes are queued at
// stimulus time and popped on each framebuffer handshake.
module tb_pixel_write_sink;
  import gh_video_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                i_plot;
  logic [X_W-1:0]      i_x;
  logic [Y_W-1:0]      i_y;
  logic [COLOUR_W-1:0] i_colour;
  logic                i_clear;
  logic                o_busy;
  logic                o_clip;
  logic                o_overflow;
  logic                o_clear_done;

  pixel_write_sink_if fb();

  pixel_write_sink dut (
    .clk          (clk),
    .reset        (reset),
    .i_plot       (i_plot),
    .i_x          (i_x),
    .i_y          (i_y),
    .i_colour     (i_colour),
    .i_clear      (i_clear),
    .o_busy       (o_busy),
    .o_clip       (o_clip),
    .o_overflow   (o_overflow),
    .o_clear_done (o_clear_done),
    .fb           (fb)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned n_done = 0;
  px_wr_t      sb[$];

  task automatic chk(input string tag,
                     input int unsigned got,
                     input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  logic              m_stall = 1'b0;
  logic [ADDR_W-1:0] m_addr;
  logic [COLOUR_W-1:0] m_data;

  always @(negedge clk) begin
    if (reset) begin
      if (o_clear_done) n_done++;
      if (m_stall && fb.wr_en) begin
        chk("hold_addr", fb.wr_addr, m_addr);
        chk("hold_data", fb.wr_data, m_data);
      end
      if (fb.wr_en && fb.wr_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_wr", 1, 0);
        end else begin
          px_wr_t e;
          e = sb.pop_front();
          chk("wr_addr", fb.wr_addr, e.addr);
          chk("wr_data", fb.wr_data, e.colour);
        end
      end
      m_stall = fb.wr_en && !fb.wr_ready;
      m_addr  = fb.wr_addr;
      m_data  = fb.wr_data;
    end else begin
      m_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_px(input int x, input int y, input int c);
    px_wr_t e;
    e.addr   = ADDR_W'(y * SCREEN_W + x);
    e.colour = COLOUR_W'(c);
    sb.push_back(e);
  endtask

  task automatic expect_sweep(input int n);
    px_wr_t e;
    for (int i = 0; i < n; i++) begin
      e.addr   = ADDR_W'(i);
      e.colour = CLEAR_COLOUR;
      sb.push_back(e);
    end
  endtask

  task automatic drive_plot(input int x, input int y, input int c);
    i_plot   = 1'b1;
    i_x      = X_W'(x);
    i_y      = Y_W'(y);
    i_colour = COLOUR_W'(c);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !fb.wr_en) break;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic single_plot();
    tick();
    drive_plot(5, 3, 7);
    expect_px(5, 3, 7);
    tick();
    i_plot = 1'b0;
    @(negedge clk);
    chk("t1_wr_en_n1", fb.wr_en, 0);
    chk("t1_clip_n1", o_clip, 0);
    tick();
    @(negedge clk);
    chk("t1_wr_en_n2", fb.wr_en, 1);
    chk("t1_addr_n2", fb.wr_addr, 485);
    tick();
    @(negedge clk);
    chk("t1_wr_en_n3", fb.wr_en, 0);
    chk("t1_sb_empty", sb.size(), 0);
  endtask

  task automatic clip_plot(input int x, input int y);
    tick();
    drive_plot(x, y, 2);
    tick();
    i_plot = 1'b0;
    @(negedge clk);
    chk("t2_clip", o_clip, 1);
    chk("t2_wr_en", fb.wr_en, 0);
    tick();
    @(negedge clk);
    chk("t2_clip_pulse", o_clip, 0);
    chk("t2_overflow", o_overflow, 0);
    chk("t2_wr_en_after", fb.wr_en, 0);
  endtask

  initial begin
    int done0;
    bit busy_ok;
    reset       = 1'b0;
    i_plot      = 1'b0;
    i_x         = '0;
    i_y         = '0;
    i_colour    = '0;
    i_clear     = 1'b0;
    fb.wr_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_wr_en", fb.wr_en, 0);
    chk("rst_addr", fb.wr_addr, 0);
    chk("rst_data", fb.wr_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_clip", o_clip, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_done", o_clear_done, 0);
    tick();
    reset       = 1'b1;
    fb.wr_ready = 1'b1;

    single_plot();
    clip_plot(160, 0);
    clip_plot(0, 120);

    // back-to-back plots against a stalled framebuffer
    tick();
    fb.wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      drive_plot(10 + i, 20 + i, i + 1);
      if (i < 4) expect_px(10 + i, 20 + i, i + 1);
      @(negedge clk);
      chk($sformatf("t3_busy_%0d", i), o_busy, (i == 4) ? 1 : 0);
    end
    tick();
    i_plot = 1'b0;
    @(negedge clk);
    chk("t3_overflow", o_overflow, 1);
    tick();
    fb.wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t3_burst_%0d", i), fb.wr_en, 1);
      tick();
    end
    @(negedge clk);
    chk("t3_idle", fb.wr_en, 0);
    chk("t3_sb_empty", sb.size(), 0);
    chk("t3_ovf_sticky", o_overflow, 1);

    // full-screen clear from idle
    tick();
    i_clear = 1'b1;
    expect_sweep(NPIX);
    @(negedge clk);
    chk("t4_busy_req", o_busy, 1);
    tick();
    i_clear = 1'b0;
    @(negedge clk);
    chk("t4_ovf_cleared", o_overflow, 0);
    busy_ok = 1'b1;
    for (int i = 0; i < NPIX + 10; i++) begin
      if (!fb.wr_en) break;
      if (!o_busy) busy_ok = 1'b0;
      @(negedge clk);
    end
    chk("t4_busy_thru", busy_ok, 1);
    chk("t4_sb_empty", sb.size(), 0);
    chk("t4_done", o_clear_done, 1);
    tick();
    @(negedge clk);
    chk("t4_done_pulse", o_clear_done, 0);

    // clear requested while a write is stalled with two queued
    tick();
    fb.wr_ready = 1'b0;
    drive_plot(1, 2, 3);
    expect_px(1, 2, 3);
    tick();
    drive_plot(159, 119, 5);
    tick();
    i_plot = 1'b0;
    tick();
    expect_sweep(NPIX);
    expect_px(159, 119, 5);
    done0 = n_done;
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    @(negedge clk);
    chk("t5_head_held", fb.wr_addr, 2 * SCREEN_W + 1);
    tick();
    fb.wr_ready = 1'b1;
    drain("t5_drain", NPIX + 50);
    chk("t5_done_cnt", n_done, done0 + 1);

    // reset in the middle of a sweep
    tick();
    i_clear = 1'b1;
    expect_sweep(100);
    tick();
    i_clear = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("t6_wr_en", fb.wr_en, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_done", o_clear_done, 0);
    chk("t6_sb_empty", sb.size(), 0);
    single_plot();
    tick();
    fb.wr_ready = 1'b0;
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    @(negedge clk);
    chk("t6_sweep_zero", fb.wr_addr, 0);
    chk("t6_sweep_en", fb.wr_en, 1);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    fb.wr_ready = 1'b1;
    @(negedge clk);
    chk("t6_final_idle", fb.wr_en, 0);
    chk("t6_final_sb", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
